// File: rtl/pc_seq_if.sv
// ---------------------------------------------------------------------------
// pc_seq_if -- bundle between the core datapath and the next-PC sequencer.
//
// Handshake: there is no valid/ready pair on this interface. Every signal is
// a plain level that is sampled each cycle. The master (the core) drives the
// current PC and the control-flow requests. The slave (pc_sequencer) drives
// the next PC combinationally and reports its registered status.
//
// Signals (master -> slave):
//   pc, stall, branch_taken, branch_target, jump, call, jump_target,
//   ret, halt, irq, mret
// Signals (slave -> master):
//   pc_next, halted, in_trap, epc, ras_err
// ---------------------------------------------------------------------------
interface pc_seq_if #(
    parameter int BUS_WIDTH = 16
);
    logic [BUS_WIDTH-1:0] pc;
    logic                 stall;
    logic                 branch_taken;
    logic [BUS_WIDTH-1:0] branch_target;
    logic                 jump;
    logic                 call;
    logic [BUS_WIDTH-1:0] jump_target;
    logic                 ret;
    logic                 halt;
    logic                 irq;
    logic                 mret;

    logic [BUS_WIDTH-1:0] pc_next;
    logic                 halted;
    logic                 in_trap;
    logic [BUS_WIDTH-1:0] epc;
    logic                 ras_err;

    modport master (
        output pc, stall, branch_taken, branch_target, jump, call,
               jump_target, ret, halt, irq, mret,
        input  pc_next, halted, in_trap, epc, ras_err
    );

    modport slave (
        input  pc, stall, branch_taken, branch_target, jump, call,
               jump_target, ret, halt, irq, mret,
        output pc_next, halted, in_trap, epc, ras_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer -- next-PC controller for the 16-bit single-cycle core.
//
// Chooses each cycle between sequential fetch, branch, jump/call, return,
// interrupt entry and interrupt return. Keeps a circular return-address
// stack, the exception PC and a BOOT/RUN/HALTED state machine. The PC
// register itself has no reset, so it is initialised only via pc_next.
//
// Ports:
//   clk      in   rising-edge clock (shared with the PC register)
//   rst      in   synchronous active-high reset
//   bus      slave modport of pc_seq_if (PC, control requests, pc_next,
//                 halted, in_trap, epc, ras_err)
//   state_o  out  debug view of the FSM state (0 BOOT, 1 RUN, 2 HALTED)
//
// Configuration macro: PC_SEQ_IRQ_EN
//   defined   -> irq/mret/epc/in_trap active, irq wakes HALTED
//   undefined -> irq ignored, mret is a plain pc+1, epc/in_trap stay 0
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter int                   BUS_WIDTH    = 16,
    parameter logic [BUS_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [BUS_WIDTH-1:0] TRAP_VECTOR  = BUS_WIDTH'(16'h0010),
    parameter int                   RAS_DEPTH    = 4
) (
    input  logic         clk,
    input  logic         rst,
    pc_seq_if.slave      bus,
    output logic [1:0]   state_o
);

`ifdef PC_SEQ_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    localparam int            PW       = $clog2(RAS_DEPTH);
    localparam logic [PW:0]   RAS_FULL = (PW+1)'(RAS_DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic                 halted_q;
    logic                 in_trap_q;
    logic [BUS_WIDTH-1:0] epc_q;
    logic                 ras_err_q, ras_err_d;

    // Return-address stack: top_q is the next free slot, cnt_q saturates at
    // RAS_DEPTH so a push when full silently overwrites the oldest entry.
    logic [BUS_WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]        top_q;
    logic [PW:0]          cnt_q;

    logic [BUS_WIDTH-1:0] pc_next;
    logic [BUS_WIDTH-1:0] pc_inc;
    logic [PW-1:0]        top_m1;
    logic                 take_irq;
    logic                 take_mret;
    logic                 do_push;
    logic                 do_pop;

    assign pc_inc = bus.pc + 1'b1;   // wraps modulo 2^BUS_WIDTH
    assign top_m1 = top_q - 1'b1;

    // Next-PC selection and action decode. Only one action is chosen, so
    // lower-priority requests in the same cycle have no side effects.
    always_comb begin
        pc_next   = pc_inc;
        state_d   = state_q;
        take_irq  = 1'b0;
        take_mret = 1'b0;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        ras_err_d = 1'b0;
        if (rst || state_q == ST_BOOT) begin
            pc_next = RESET_VECTOR;
            state_d = ST_RUN;
        end else if (state_q == ST_HALTED) begin
            pc_next = bus.pc;
            if (IRQ_EN && bus.irq && !in_trap_q) begin
                pc_next  = TRAP_VECTOR;
                take_irq = 1'b1;
                state_d  = ST_RUN;
            end
        end else begin
            if (bus.stall) begin
                pc_next = bus.pc;
            end else if (IRQ_EN && bus.irq && !in_trap_q) begin
                pc_next  = TRAP_VECTOR;
                take_irq = 1'b1;
            end else if (bus.mret) begin
                if (IRQ_EN) begin
                    pc_next   = epc_q;
                    take_mret = 1'b1;
                end else begin
                    pc_next = pc_inc;
                end
            end else if (bus.jump) begin
                pc_next = bus.jump_target;
                if (bus.call) begin
                    do_push   = 1'b1;
                    ras_err_d = (cnt_q == RAS_FULL);
                end
            end else if (bus.ret) begin
                if (cnt_q == '0) begin
                    // Underflow: nothing sensible to return to, so trap.
                    pc_next   = TRAP_VECTOR;
                    ras_err_d = 1'b1;
                end else begin
                    pc_next = ras_q[top_m1];
                    do_pop  = 1'b1;
                end
            end else if (bus.branch_taken) begin
                pc_next = bus.branch_target;
            end else if (bus.halt) begin
                // Hold the halt instruction's PC so the core parks on it.
                pc_next = bus.pc;
                state_d = ST_HALTED;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_BOOT;
            halted_q  <= 1'b0;
            in_trap_q <= 1'b0;
            epc_q     <= '0;
            ras_err_q <= 1'b0;
            top_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            halted_q  <= (state_d == ST_HALTED);
            ras_err_q <= ras_err_d;
            if (take_irq) begin
                epc_q     <= bus.pc;   // interrupted instruction re-executes
                in_trap_q <= 1'b1;
            end else if (take_mret) begin
                in_trap_q <= 1'b0;
            end
            if (do_push) begin
                ras_q[top_q] <= pc_inc;
                top_q        <= top_q + 1'b1;
                if (cnt_q != RAS_FULL) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else if (do_pop) begin
                top_q <= top_m1;
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign bus.pc_next = pc_next;
    assign bus.halted  = halted_q;
    assign bus.in_trap = in_trap_q;
    assign bus.epc     = epc_q;
    assign bus.ras_err = ras_err_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer -- directed vector table plus randomized cycles, all
// checked against a queue-based reference model of the next-PC rules.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam logic [15:0] RV    = 16'h0000;
    localparam logic [15:0] TV    = 16'h0010;
    localparam int          DEPTH = 4;

`ifdef PC_SEQ_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    // control word bit positions
    localparam logic [8:0] NON = 9'h000;
    localparam logic [8:0] RST = 9'h100;
    localparam logic [8:0] STL = 9'h080;
    localparam logic [8:0] BR  = 9'h040;
    localparam logic [8:0] JMP = 9'h020;
    localparam logic [8:0] CAL = 9'h010;
    localparam logic [8:0] RET = 9'h008;
    localparam logic [8:0] HLT = 9'h004;
    localparam logic [8:0] IRQ = 9'h002;
    localparam logic [8:0] MRT = 9'h001;

    typedef struct {
        logic [8:0]  ctl;
        bit          fol;   // use the tb PC register instead of pc field
        logic [15:0] pc;
        logic [15:0] jt;
        logic [15:0] bt;
        bit          cn;    // table expectations present
        logic [15:0] en;    // expected pc_next
        bit          ee;    // expected ras_err after the edge
        bit          eh;    // expected halted after the edge
    } vec_t;

    typedef enum int {M_BOOT, M_RUN, M_HALT} mode_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_seq_if #(.BUS_WIDTH(16)) bus();
    logic [1:0] dbg_state;

    pc_sequencer #(
        .BUS_WIDTH(16), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .state_o(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    mode_t       m_mode = M_BOOT, n_mode;
    bit          m_trap = 1'b0, n_trap;
    logic [15:0] m_epc = 16'h0, n_epc;
    bit          m_err = 1'b0, n_err;
    logic [15:0] m_stk[$];
    logic [15:0] n_stk[$];
    logic [15:0] exp_next;
    logic [15:0] pc_reg = 16'h0;

    function void model_eval(input logic [8:0] c, input logic [15:0] pcv,
                             input logic [15:0] jt, input logic [15:0] bt);
        logic [15:0] inc;
        inc    = pcv + 16'd1;
        n_mode = m_mode; n_trap = m_trap; n_epc = m_epc; n_stk = m_stk; n_err = 1'b0;
        exp_next = inc;
        if (c[8]) begin
            exp_next = RV; n_mode = M_BOOT; n_trap = 1'b0; n_epc = 16'h0; n_stk.delete();
        end else if (m_mode == M_BOOT) begin
            exp_next = RV; n_mode = M_RUN;
        end else if (m_mode == M_HALT) begin
            exp_next = pcv;
            if (IRQ_ON && c[1] && !m_trap) begin
                exp_next = TV; n_epc = pcv; n_trap = 1'b1; n_mode = M_RUN;
            end
        end else if (c[7]) begin
            exp_next = pcv;
        end else if (IRQ_ON && c[1] && !m_trap) begin
            exp_next = TV; n_epc = pcv; n_trap = 1'b1;
        end else if (c[0]) begin
            if (IRQ_ON) begin exp_next = m_epc; n_trap = 1'b0; end
            else exp_next = inc;
        end else if (c[5]) begin
            exp_next = jt;
            if (c[4]) begin
                n_stk.push_back(inc);
                if (n_stk.size() > DEPTH) begin
                    void'(n_stk.pop_front());
                    n_err = 1'b1;
                end
            end
        end else if (c[3]) begin
            if (n_stk.size() == 0) begin exp_next = TV; n_err = 1'b1; end
            else exp_next = n_stk.pop_back();
        end else if (c[6]) begin
            exp_next = bt;
        end else if (c[2]) begin
            exp_next = pcv; n_mode = M_HALT;
        end
    endfunction

    function void model_commit();
        m_mode = n_mode; m_trap = n_trap; m_epc = n_epc; m_stk = n_stk; m_err = n_err;
    endfunction

    // ---------------- driver ----------------
    task automatic apply(input vec_t v);
        logic [15:0] pcv;
        @(negedge clk);
        pcv               = v.fol ? pc_reg : v.pc;
        rst               = v.ctl[8];
        bus.stall         = v.ctl[7];
        bus.branch_taken  = v.ctl[6];
        bus.jump          = v.ctl[5];
        bus.call          = v.ctl[4];
        bus.ret           = v.ctl[3];
        bus.halt          = v.ctl[2];
        bus.irq           = v.ctl[1];
        bus.mret          = v.ctl[0];
        bus.pc            = pcv;
        bus.jump_target   = v.jt;
        bus.branch_target = v.bt;
        model_eval(v.ctl, pcv, v.jt, v.bt);
        #1;
        check16("pc_next", bus.pc_next, exp_next);
        if (v.cn) check16("pc_next_vec", bus.pc_next, v.en);
        @(posedge clk);
        model_commit();
        pc_reg = exp_next;
        #1;
        check1("halted", bus.halted, m_mode == M_HALT);
        check1("in_trap", bus.in_trap, m_trap);
        check16("epc", bus.epc, m_epc);
        check1("ras_err", bus.ras_err, m_err);
        if (v.cn) begin
            check1("ras_err_vec", bus.ras_err, v.ee);
            check1("halted_vec", bus.halted, v.eh);
        end
    endtask

    // ---------------- test ----------------
    vec_t tbl[$];

    initial begin
        rst = 1'b1;
        bus.pc = '0; bus.stall = 0; bus.branch_taken = 0; bus.branch_target = '0;
        bus.jump = 0; bus.call = 0; bus.jump_target = '0; bus.ret = 0;
        bus.halt = 0; bus.irq = 0; bus.mret = 0;

        // reset with PC unknown, boot, then sequential fetch
        tbl.push_back('{RST, 0, 16'hxxxx, 16'h0, 16'h0, 1, 16'h0000, 0, 0});
        tbl.push_back('{RST, 0, 16'hxxxx, 16'h0, 16'h0, 1, 16'h0000, 0, 0});
        tbl.push_back('{NON, 1, 16'h0, 16'h0, 16'h0, 1, 16'h0000, 0, 0});
        tbl.push_back('{NON, 1, 16'h0, 16'h0, 16'h0, 1, 16'h0001, 0, 0});
        tbl.push_back('{NON, 1, 16'h0, 16'h0, 16'h0, 1, 16'h0002, 0, 0});
        tbl.push_back('{NON, 1, 16'h0, 16'h0, 16'h0, 1, 16'h0003, 0, 0});
        tbl.push_back('{NON, 1, 16'h0, 16'h0, 16'h0, 1, 16'h0004, 0, 0});
        // call at 0x0004, run to 0x0042, return, then underflow
        tbl.push_back('{JMP|CAL, 1, 16'h0, 16'h0040, 16'h0, 1, 16'h0040, 0, 0});
        tbl.push_back('{NON, 1, 16'h0, 16'h0, 16'h0, 1, 16'h0041, 0, 0});
        tbl.push_back('{NON, 1, 16'h0, 16'h0, 16'h0, 1, 16'h0042, 0, 0});
        tbl.push_back('{RET, 1, 16'h0, 16'h0, 16'h0, 1, 16'h0005, 0, 0});
        tbl.push_back('{RET, 1, 16'h0, 16'h0, 16'h0, 1, 16'h0010, 1, 0});
        tbl.push_back('{NON, 1, 16'h0, 16'h0, 16'h0, 1, 16'h0011, 0, 0});
        // five nested calls: the fifth overflows
        tbl.push_back('{JMP|CAL, 0, 16'h0100, 16'h1000, 16'h0, 1, 16'h1000, 0, 0});
        tbl.push_back('{JMP|CAL, 0, 16'h0200, 16'h2000, 16'h0, 1, 16'h2000, 0, 0});
        tbl.push_back('{JMP|CAL, 0, 16'h0300, 16'h3000, 16'h0, 1, 16'h3000, 0, 0});
        tbl.push_back('{JMP|CAL, 0, 16'h0400, 16'h4000, 16'h0, 1, 16'h4000, 0, 0});
        tbl.push_back('{JMP|CAL, 0, 16'h0500, 16'h5000, 16'h0, 1, 16'h5000, 1, 0});
        tbl.push_back('{NON, 0, 16'h0600, 16'h0, 16'h0, 1, 16'h0601, 0, 0});
        tbl.push_back('{RET, 0, 16'h0700, 16'h0, 16'h0, 1, 16'h0501, 0, 0});
        tbl.push_back('{RET, 0, 16'h0700, 16'h0, 16'h0, 1, 16'h0401, 0, 0});
        tbl.push_back('{RET, 0, 16'h0700, 16'h0, 16'h0, 1, 16'h0301, 0, 0});
        tbl.push_back('{RET, 0, 16'h0700, 16'h0, 16'h0, 1, 16'h0201, 0, 0});
        tbl.push_back('{RET, 0, 16'h0700, 16'h0, 16'h0, 1, 16'h0010, 1, 0});
        tbl.push_back('{NON, 0, 16'h0700, 16'h0, 16'h0, 1, 16'h0701, 0, 0});
        // priority: stall wins, then jump with no push and no branch
        tbl.push_back('{STL|JMP|BR, 0, 16'h0030, 16'h0080, 16'h0090, 1, 16'h0030, 0, 0});
        tbl.push_back('{JMP|BR, 0, 16'h0030, 16'h0080, 16'h0090, 1, 16'h0080, 0, 0});
        tbl.push_back('{RET, 1, 16'h0, 16'h0, 16'h0, 1, 16'h0010, 1, 0});
        tbl.push_back('{BR, 0, 16'h0050, 16'h0, 16'h0090, 1, 16'h0090, 0, 0});
        // wrap
        tbl.push_back('{NON, 0, 16'hFFFF, 16'h0, 16'h0, 1, 16'h0000, 0, 0});
        // halt at 0x0020; halted core ignores jump/ret
        tbl.push_back('{HLT, 0, 16'h0020, 16'h0, 16'h0, 1, 16'h0020, 0, 1});
        tbl.push_back('{NON, 1, 16'h0, 16'h0, 16'h0, 1, 16'h0020, 0, 1});
        tbl.push_back('{JMP|RET, 1, 16'h0, 16'h0300, 16'h0, 1, 16'h0020, 0, 1});
`ifdef PC_SEQ_IRQ_EN
        tbl.push_back('{IRQ, 1, 16'h0, 16'h0, 16'h0, 1, 16'h0010, 0, 0});
        tbl.push_back('{NON, 1, 16'h0, 16'h0, 16'h0, 1, 16'h0011, 0, 0});
        tbl.push_back('{MRT, 1, 16'h0, 16'h0, 16'h0, 1, 16'h0020, 0, 0});
`else
        tbl.push_back('{IRQ, 1, 16'h0, 16'h0, 16'h0, 1, 16'h0020, 0, 1});
`endif
        tbl.push_back('{RST, 1, 16'h0, 16'h0, 16'h0, 1, 16'h0000, 0, 0});
        tbl.push_back('{NON, 1, 16'h0, 16'h0, 16'h0, 1, 16'h0000, 0, 0});
        // interrupt entry / masking / return, irq beats call
`ifdef PC_SEQ_IRQ_EN
        tbl.push_back('{IRQ, 0, 16'h0123, 16'h0, 16'h0, 1, 16'h0010, 0, 0});
        tbl.push_back('{IRQ, 0, 16'h0010, 16'h0, 16'h0, 1, 16'h0011, 0, 0});
        tbl.push_back('{MRT, 0, 16'h0011, 16'h0, 16'h0, 1, 16'h0123, 0, 0});
        tbl.push_back('{IRQ|JMP|CAL, 0, 16'h0200, 16'h0400, 16'h0, 1, 16'h0010, 0, 0});
        tbl.push_back('{MRT, 0, 16'h0010, 16'h0, 16'h0, 1, 16'h0200, 0, 0});
        tbl.push_back('{RET, 0, 16'h0300, 16'h0, 16'h0, 1, 16'h0010, 1, 0});
`else
        tbl.push_back('{IRQ, 0, 16'h0123, 16'h0, 16'h0, 1, 16'h0124, 0, 0});
        tbl.push_back('{MRT|JMP, 0, 16'h0124, 16'h0400, 16'h0, 1, 16'h0125, 0, 0});
        tbl.push_back('{IRQ|JMP|CAL, 0, 16'h0200, 16'h0400, 16'h0, 1, 16'h0400, 0, 0});
        tbl.push_back('{RET, 0, 16'h0400, 16'h0, 16'h0, 1, 16'h0201, 0, 0});
`endif

        foreach (tbl[i]) apply(tbl[i]);

        // randomized cycles against the model
        for (int i = 0; i < 600; i++) begin
            vec_t r;
            r.ctl    = NON;
            r.ctl[8] = ($urandom_range(0, 59) == 0);
            r.ctl[7] = ($urandom_range(0, 5) == 0);
            r.ctl[6] = ($urandom_range(0, 3) == 0);
            r.ctl[5] = ($urandom_range(0, 4) == 0);
            r.ctl[4] = ($urandom_range(0, 1) == 0);
            r.ctl[3] = ($urandom_range(0, 4) == 0);
            r.ctl[2] = ($urandom_range(0, 24) == 0);
            r.ctl[1] = ($urandom_range(0, 7) == 0);
            r.ctl[0] = ($urandom_range(0, 7) == 0);
            r.fol = ($urandom_range(0, 3) != 0);
            r.pc  = 16'($urandom);
            r.jt  = 16'($urandom);
            r.bt  = 16'($urandom);
            r.cn  = 1'b0;
            r.en  = 16'h0;
            r.ee  = 1'b0;
            r.eh  = 1'b0;
            apply(r);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the 16-bit single-cycle core. Drives the `pc_next` input of the program-counter register and chooses each cycle between sequential fetch, branch, jump/call, return, interrupt entry and interrupt return. Holds a small return-address stack, the exception PC and a run/halt state machine. The PC register has no reset, so it is initialised only through `pc_next`.

## Interface
- `BUS_WIDTH`, 16, address width.
- `RESET_VECTOR`, 16'h0000, first fetch address after reset.
- `TRAP_VECTOR`, 16'h0010, interrupt and stack-underflow entry address.
- `RAS_DEPTH`, 4, return-address stack entries (power of two, ≥2).

Ports:
- `clk`  in  1  rising-edge clock, shared with the PC register.
- `rst`  in  1  synchronous, active-high reset.
- `pc`  in  BUS_WIDTH  current PC from the PC register.
- `stall`  in  1  hold the current PC.
- `branch_taken`  in  1  conditional branch resolved taken.
- `branch_target`  in  BUS_WIDTH  branch destination.
- `jump`  in  1  unconditional jump.
- `call`  in  1  qualifies `jump`: push `pc+1`.
- `jump_target`  in  BUS_WIDTH  jump/call destination.
- `ret`  in  1  pop the return-address stack.
- `halt`  in  1  halt instruction executing.
- `irq`  in  1  level interrupt request.
- `mret`  in  1  return from interrupt.
- `pc_next`  out  BUS_WIDTH  next PC, combinational.
- `halted`  out  1  state is HALTED.
- `in_trap`  out  1  interrupt handler active (interrupts masked).
- `epc`  out  BUS_WIDTH  saved interrupt return address.
- `ras_err`  out  1  one-cycle pulse on overflow or underflow.

## Operation
- States: BOOT, RUN, HALTED. `rst` forces BOOT. BOOT → RUN after one cycle. RUN → HALTED on `halt` without `stall`. HALTED → RUN on `irq` when interrupts are compiled in; otherwise HALTED exits only through `rst`.
- BOOT and during `rst`: `pc_next = RESET_VECTOR`.
- HALTED: `pc_next = pc`.
- RUN priority, highest first:
  1. `stall` → `pc`.
  2. `irq && !in_trap` → `TRAP_VECTOR`; set `epc = pc`, set `in_trap`. The interrupted instruction is re-executed.
  3. `mret` → `epc`; clear `in_trap`.
  4. `jump` → `jump_target`; if `call`, push `pc+1`.
  5. `ret` → popped value. If the stack is empty, go to `TRAP_VECTOR` and pulse `ras_err`.
  6. `branch_taken` → `branch_target`.
  7. Otherwise → `pc+1`.
- Only the selected action updates state. Inputs of lower priority in the same cycle are ignored and produce no push or pop.
- `halt` is ignored in a cycle where an earlier action is selected.
- Arithmetic: `pc+1` is modulo 2^BUS_WIDTH, so 16'hFFFF → 16'h0000.
- Stack is circular with a count field. A push when full overwrites the oldest entry, keeps count at `RAS_DEPTH`, and pulses `ras_err`.
- Reset values: `halted=0`, `in_trap=0`, `epc=0`, `ras_err=0`, stack count 0, `pc_next=RESET_VECTOR`.

## Timing
- `pc_next` is combinational from the inputs and registered state, with zero latency. The PC register captures it on the same edge.
- `epc`, `in_trap`, stack contents, stack count and state update on the rising `clk` edge of the cycle the action is selected.
- `ras_err` is registered, so it is high for the single cycle after the faulting edge.
- `rst` held mid-operation: on the next edge the stack empties, `in_trap` and `epc` clear, and the state enters BOOT. `pc_next` shows `RESET_VECTOR` for the whole reset and for one BOOT cycle afterwards.
- An interrupt in the same cycle as `call` takes the interrupt; no push occurs.

## Configuration
- `PC_SEQ_IRQ_EN` defined: `irq`, `mret`, `epc` and `in_trap` behave as described above, and `irq` wakes HALTED.
- `PC_SEQ_IRQ_EN` undefined:
  - `irq` is ignored and `mret` acts as a sequential `pc+1`.
  - `epc` and `in_trap` are tied to 0.
  - Stack underflow still redirects to `TRAP_VECTOR`.

## Test plan
- Reset: assert `rst` for 2 cycles with `pc` at X → `pc_next=16'h0000` for 3 cycles, then `pc+1` sequencing 0,1,2,3.
- Call/return: at `pc=16'h0004`, `jump=call=1`, `jump_target=16'h0040` → next PC 16'h0040. Then `ret` at 16'h0042 → 16'h0005, and the stack is empty.
- Stack boundaries with `RAS_DEPTH=4`:
  - 5 nested calls → `ras_err` pulses once, and 4 returns give the last 4 return addresses.
  - A 5th `ret` → `pc_next=16'h0010` and `ras_err` pulses.
- Priority: `stall`, `jump` and `branch_taken` all high → `pc_next=pc`. Drop `stall` → `jump_target`, with no push or branch.
- Interrupt (macro defined): `irq` at `pc=16'h0123` → 16'h0010, `epc=16'h0123`, `in_trap=1`. A second `irq` is ignored. `mret` → 16'h0123 and `in_trap=0`.
- Halt and wrap:
  - `halt` at 16'h0020 → `pc_next` stays 16'h0020 and `halted=1`. `irq` resumes at 16'h0010, or, without the macro, the core stays halted until `rst`.
  - `pc=16'hFFFF` sequential → 16'h0000.
